// File: rtl/spi_cmd_decoder_pkg.sv
// spi_cmd_pkg: shared definitions for the SPI command decoder.
//   state_t       decoder FSM state encoding
//   CMD_*         command byte field positions
//   ERRCNT_ADDR   register address of the optional error counter
//                 (only decoded when SPI_CMD_ERRCNT_EN is defined)
package spi_cmd_pkg;

    typedef enum logic [1:0] {
        S_CMD   = 2'd0,
        S_WDATA = 2'd1,
        S_RESP  = 2'd2,
        S_ERR   = 2'd3
    } state_t;

    localparam int CMD_WRITE_BIT = 7;
    localparam int CMD_RSVD_MSB  = 6;
    localparam int CMD_RSVD_LSB  = 4;

    localparam logic [3:0] ERRCNT_ADDR = 4'hF;

endpackage

// File: rtl/cdc_sync_edge.sv
// cdc_sync_edge: multi-flop synchroniser for one asynchronous level with a
// rising-edge detect on the synchronised side.
//   clk   destination clock
//   rst   synchronous active-high reset; all flops load RST_VAL
//   d     asynchronous input level
//   q     synchronised level
//   rise  one-cycle pulse when q goes 0 -> 1
module cdc_sync_edge #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q,
    output logic rise
);

    logic [STAGES-1:0] sync_p;
    logic              prev;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_p <= {STAGES{RST_VAL}};
            prev   <= RST_VAL;
        end else begin
            sync_p <= {sync_p[STAGES-2:0], d};
            prev   <= sync_p[STAGES-1];
        end
    end

    assign q    = sync_p[STAGES-1];
    assign rise = q & ~prev;

endmodule

// File: rtl/spi_cmd_decoder.sv
// spi_cmd_decoder: turns bytes from the SPI slave front end into register
// reads/writes of a small register file, all in the sysclk domain.
//   sysclk        system clock
//   reset         synchronous active-high reset
//   iRxReady      byte-valid level from SPI front end (asynchronous)
//   iRx           received byte, stable around iRxReady rising
//   iSPICS        raw chip select, active low (asynchronous)
//   oTxReady      read data valid toward the SPI front end
//   oTx           read data byte (held while oTxReady is low)
//   oRegs         flattened register file, reg n at [8n+7:8n]
//   oWriteStrobe  one-cycle pulse per committed register write
//   probe         {state, addr, 2'b0, last byte}
// Optional build macro SPI_CMD_ERRCNT_EN adds a saturating error counter
// readable (and cleared by any write) at address 4'hF.
module spi_cmd_decoder
    import spi_cmd_pkg::*;
#(
    parameter int         NUM_REGS    = 4,
    parameter logic [7:0] RESET_VAL   = 8'h00,
    parameter int         SYNC_STAGES = 2
) (
    input  logic                  sysclk,
    input  logic                  reset,
    input  logic                  iRxReady,
    input  logic [7:0]            iRx,
    input  logic                  iSPICS,
    output logic                  oTxReady,
    output logic [7:0]            oTx,
    output logic [NUM_REGS*8-1:0] oRegs,
    output logic                  oWriteStrobe,
    output logic [15:0]           probe
);

    localparam logic [3:0] LAST_ADDR = 4'(NUM_REGS - 1);

    function automatic logic addr_valid(input logic [3:0] a);
`ifdef SPI_CMD_ERRCNT_EN
        return (a <= LAST_ADDR) || (a == ERRCNT_ADDR);
`else
        return a <= LAST_ADDR;
`endif
    endfunction

    function automatic logic [3:0] addr_next(input logic [3:0] a);
`ifdef SPI_CMD_ERRCNT_EN
        if (a == ERRCNT_ADDR) return a;
`endif
        if (a == LAST_ADDR) return 4'd0;
        return a + 4'd1;
    endfunction

    state_t     state, state_nx;
    logic [3:0] addr;
    logic [7:0] byte_q;
    logic [7:0] regs [NUM_REGS];
    logic       rd_pend;
    logic       armed;
    logic [SYNC_STAGES:0] settle;

    logic rx_q, byte_evt, cs_q, cs_rise;
    logic evt, load_cmd, cmd_ok, rd_start, rd_adv, do_write, err_entry;
    logic [7:0] cmd_val, cur_val;

    // Synchroniser stage: CS resets deselected, rx_ready resets idle.
    cdc_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_rx_sync (
        .clk(sysclk), .rst(reset), .d(iRxReady), .q(rx_q), .rise(byte_evt)
    );
    cdc_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_cs_sync (
        .clk(sysclk), .rst(reset), .d(iSPICS), .q(cs_q), .rise(cs_rise)
    );

    logic unused_ok;
    assign unused_ok = &{1'b0, rx_q, cs_rise};

    // The CS chain reloads 1 on reset, so its output is only trusted for
    // arming once the chain has been refilled from the real pin.
    always_ff @(posedge sysclk) begin
        if (reset) begin
            settle <= '0;
            armed  <= 1'b0;
        end else begin
            settle <= {settle[SYNC_STAGES-1:0], 1'b1};
            if (cs_q && settle[SYNC_STAGES]) armed <= 1'b1;
        end
    end

    // Decode stage: CS high wins over a coincident byte.
    assign evt    = byte_evt & armed & ~cs_q;
    assign cmd_ok = (iRx[CMD_RSVD_MSB:CMD_RSVD_LSB] == 3'b000) && addr_valid(iRx[3:0]);

    always_ff @(posedge sysclk) begin
        if (reset) state <= S_CMD;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        if (cs_q) begin
            state_nx = S_CMD;
        end else if (evt && state == S_CMD) begin
            if (!cmd_ok)                state_nx = S_ERR;
            else if (iRx[CMD_WRITE_BIT]) state_nx = S_WDATA;
            else                        state_nx = S_RESP;
        end
    end

    always_comb begin
        load_cmd  = evt && (state == S_CMD);
        rd_start  = load_cmd && cmd_ok && !iRx[CMD_WRITE_BIT];
        err_entry = load_cmd && !cmd_ok;
        do_write  = evt && (state == S_WDATA);
        rd_adv    = evt && (state == S_RESP);
    end

`ifdef SPI_CMD_ERRCNT_EN
    logic [7:0] errcnt;

    always_ff @(posedge sysclk) begin
        if (reset)                                errcnt <= 8'h00;
        else if (do_write && addr == ERRCNT_ADDR) errcnt <= 8'h00;
        else if (err_entry && errcnt != 8'hFF)    errcnt <= errcnt + 8'h01;
    end
`endif

    // Read muxes: one for the address in the incoming command byte, one for
    // the current burst address.
    always_comb begin
        cmd_val = 8'h00;
        cur_val = 8'h00;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (iRx[3:0] == 4'(i)) cmd_val = regs[i];
            if (addr == 4'(i))     cur_val = regs[i];
        end
`ifdef SPI_CMD_ERRCNT_EN
        if (iRx[3:0] == ERRCNT_ADDR) cmd_val = errcnt;
        if (addr == ERRCNT_ADDR)     cur_val = errcnt;
`endif
    end

    // Register stage: address, read response and register file.
    always_ff @(posedge sysclk) begin
        if (reset) begin
            addr         <= 4'd0;
            byte_q       <= 8'h00;
            oTx          <= 8'h00;
            oTxReady     <= 1'b0;
            rd_pend      <= 1'b0;
            oWriteStrobe <= 1'b0;
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= RESET_VAL;
        end else begin
            oWriteStrobe <= do_write;
            if (evt) byte_q <= iRx;

            if (cs_q)                      addr <= 4'd0;
            else if (load_cmd)             addr <= iRx[3:0];
            else if (do_write || rd_adv)   addr <= addr_next(addr);

            for (int i = 0; i < NUM_REGS; i++)
                if (do_write && addr == 4'(i)) regs[i] <= iRx;

            // Burst read: the dummy byte drops ready, the following cycle
            // presents the next register at the advanced address.
            if (cs_q) begin
                oTxReady <= 1'b0;
                rd_pend  <= 1'b0;
            end else if (rd_start) begin
                oTx      <= cmd_val;
                oTxReady <= 1'b1;
            end else if (rd_adv) begin
                oTxReady <= 1'b0;
                rd_pend  <= 1'b1;
            end else if (rd_pend && state == S_RESP) begin
                oTx      <= cur_val;
                oTxReady <= 1'b1;
                rd_pend  <= 1'b0;
            end
        end
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
        assign oRegs[8*g +: 8] = regs[g];
    end

    assign probe = {state, addr, 2'b00, byte_q};

endmodule

// File: tb/tb_spi_cmd_decoder.sv
// tb_spi_cmd_decoder: directed bench for spi_cmd_decoder with NUM_REGS=4,
// SYNC_STAGES=2. Build with SPI_CMD_ERRCNT_EN to also cover the error counter.
module tb_spi_cmd_decoder;

    logic        sysclk = 1'b0;
    logic        reset;
    logic        iRxReady;
    logic [7:0]  iRx;
    logic        iSPICS;
    logic        oTxReady;
    logic [7:0]  oTx;
    logic [31:0] oRegs;
    logic        oWriteStrobe;
    logic [15:0] probe;

    int n_checks = 0;
    int n_fail   = 0;
    int strobe_cnt = 0;
    int s0;

    spi_cmd_decoder #(.NUM_REGS(4), .RESET_VAL(8'h00), .SYNC_STAGES(2)) dut (
        .sysclk(sysclk), .reset(reset), .iRxReady(iRxReady), .iRx(iRx),
        .iSPICS(iSPICS), .oTxReady(oTxReady), .oTx(oTx), .oRegs(oRegs),
        .oWriteStrobe(oWriteStrobe), .probe(probe)
    );

    always #5 sysclk = ~sysclk;

    always @(negedge sysclk) if (oWriteStrobe) strobe_cnt++;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge sysclk);
    endtask

    task automatic send_byte(input logic [7:0] b);
        iRx = b;
        wait_cyc(2);
        iRxReady = 1'b1;
        wait_cyc(6);
        iRxReady = 1'b0;
        wait_cyc(6);
    endtask

    task automatic cs_low;
        iSPICS = 1'b0;
        wait_cyc(6);
    endtask

    task automatic cs_high;
        iSPICS = 1'b1;
        wait_cyc(6);
    endtask

    initial begin
        reset = 1'b1; iRxReady = 1'b0; iRx = 8'h00; iSPICS = 1'b1;
        wait_cyc(3);
        check_eq("rst_txready", {31'd0, oTxReady}, 32'd0);
        check_eq("rst_tx", {24'd0, oTx}, 32'd0);
        check_eq("rst_regs", oRegs, 32'h0000_0000);
        check_eq("rst_strobe", {31'd0, oWriteStrobe}, 32'd0);
        check_eq("rst_probe", {16'd0, probe}, 32'd0);
        reset = 1'b0;
        wait_cyc(6);

        // single write to reg1
        s0 = strobe_cnt;
        cs_low; send_byte(8'h81); send_byte(8'h3C); cs_high;
        check_eq("wr1_regs", oRegs, 32'h0000_3C00);
        check_eq("wr1_strobes", strobe_cnt - s0, 1);

        // burst write with wrap
        s0 = strobe_cnt;
        cs_low; send_byte(8'h82); send_byte(8'hA1); send_byte(8'hB2); send_byte(8'hC3); cs_high;
        check_eq("burst_regs", oRegs, 32'hB2A1_3CC3);
        check_eq("burst_strobes", strobe_cnt - s0, 3);

        // preload reg0=11, reg1=22
        s0 = strobe_cnt;
        cs_low; send_byte(8'h80); send_byte(8'h11); send_byte(8'h22); cs_high;
        check_eq("pre_regs", oRegs, 32'hB2A1_2211);
        check_eq("pre_strobes", strobe_cnt - s0, 2);

        // burst read
        cs_low;
        check_eq("rd_idle_ready", {31'd0, oTxReady}, 32'd0);
        send_byte(8'h00);
        check_eq("rd0_ready", {31'd0, oTxReady}, 32'd1);
        check_eq("rd0_tx", {24'd0, oTx}, 32'h11);
        send_byte(8'hFF);
        check_eq("rd1_ready", {31'd0, oTxReady}, 32'd1);
        check_eq("rd1_tx", {24'd0, oTx}, 32'h22);
        check_eq("rd1_state_addr", {26'd0, probe[15:10]}, 32'b10_0001);
        iSPICS = 1'b1;
        wait_cyc(4);
        check_eq("rd_end_ready", {31'd0, oTxReady}, 32'd0);
        check_eq("rd_end_tx_hold", {24'd0, oTx}, 32'h22);
        wait_cyc(4);

        // invalid address
        s0 = strobe_cnt;
        cs_low; send_byte(8'h85); send_byte(8'h77);
        check_eq("err_state", {30'd0, probe[15:14]}, 32'd3);
        check_eq("err_ready", {31'd0, oTxReady}, 32'd0);
        cs_high;
        check_eq("err_regs", oRegs, 32'hB2A1_2211);
        check_eq("err_strobes", strobe_cnt - s0, 0);
`ifdef SPI_CMD_ERRCNT_EN
        cs_low; send_byte(8'h0F);
        check_eq("errcnt_ready", {31'd0, oTxReady}, 32'd1);
        check_eq("errcnt_val", {24'd0, oTx}, 32'h01);
        cs_high;
`endif

        // reset mid-frame with CS held low
        s0 = strobe_cnt;
        cs_low; send_byte(8'h81);
        reset = 1'b1; wait_cyc(1); reset = 1'b0;
        send_byte(8'h55);
        check_eq("rstmid_regs", oRegs, 32'h0000_0000);
        check_eq("rstmid_strobes", strobe_cnt - s0, 0);
        check_eq("rstmid_state", {30'd0, probe[15:14]}, 32'd0);
        cs_high; cs_low; send_byte(8'h81); send_byte(8'h5A); cs_high;
        check_eq("rstmid_rewrite", oRegs, 32'h0000_5A00);

        // CS rises together with the byte strobe
        s0 = strobe_cnt;
        cs_low; send_byte(8'h81);
        iRx = 8'h99;
        wait_cyc(2);
        iRxReady = 1'b1; iSPICS = 1'b1;
        wait_cyc(6);
        iRxReady = 1'b0;
        wait_cyc(6);
        check_eq("cscoinc_regs", oRegs, 32'h0000_5A00);
        check_eq("cscoinc_strobes", strobe_cnt - s0, 0);
        check_eq("cscoinc_state_addr", {26'd0, probe[15:10]}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
